// File: rtl/pingpong_frame_ram_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pingpong_frame_ram_pkg : shared state encoding and lane helpers
// Revision 1.0
// ---------------------------------------------------------------------------
package pingpong_frame_ram_pkg;

  localparam logic [0:0] ST_FILL      = 1'b0;
  localparam logic [0:0] ST_WAIT_SWAP = 1'b1;

  function automatic int unsigned lanes_of(input int unsigned size, input int unsigned byte_w);
    return size / byte_w;
  endfunction

  function automatic bit geometry_ok(input int unsigned size, input int unsigned byte_w,
                                     input int unsigned depth);
    return (byte_w != 0) && (size >= byte_w) && ((size % byte_w) == 0) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pingpong_frame_ram_sdp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdp_ram_be : single-clock simple dual-port RAM, per-lane write enables,
//              one-cycle registered read (block-RAM inference template)
// Revision 1.0
// ---------------------------------------------------------------------------
module sdp_ram_be #(
  parameter  int unsigned WIDTH  = 24,
  parameter  int unsigned ADDR_W = 10,
  parameter  int unsigned BYTE_W = 8,
  localparam int unsigned LANES  = WIDTH / BYTE_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [LANES-1:0]  be,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int unsigned WORDS = 1 << ADDR_W;

  // One narrow array per lane keeps each lane a plain single-write-port RAM.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [BYTE_W-1:0] mem [WORDS];
    logic [BYTE_W-1:0] r_q;

    always_ff @(posedge clk) begin
      if (we && be[g]) mem[waddr] <= wdata[g*BYTE_W +: BYTE_W];
      if (re)          r_q        <= mem[raddr];
    end

    assign rdata[g*BYTE_W +: BYTE_W] = r_q;
  end

endmodule
`default_nettype wire

// File: rtl/pingpong_frame_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pingpong_frame_ram : double-buffered frame store with tear-free bank swap
// Revision 1.0
// ---------------------------------------------------------------------------
module pingpong_frame_ram
  import pingpong_frame_ram_pkg::*;
#(
  parameter  int unsigned SIZE    = 24,
  parameter  int unsigned DEPTH   = 512,
  parameter  int unsigned BYTE_W  = 8,
  parameter  int unsigned OUT_REG = 0,
  localparam int unsigned LANES   = lanes_of(SIZE, BYTE_W),
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    waddr,
  input  logic [SIZE-1:0]  write_data,
  input  logic [LANES-1:0] write_be,
  input  logic             write_en,
  input  logic             wr_done,
  output logic             wr_ready,
  output logic             wr_overflow,
  input  logic [AW-1:0]    raddr,
  input  logic             read_en,
  output logic [SIZE-1:0]  read_data,
  output logic             read_valid,
  input  logic             rd_done,
  output logic             frame_avail,
  output logic             swap,
  output logic             wr_bank
);

  if (!geometry_ok(SIZE, BYTE_W, DEPTH)) begin : g_bad_geometry
    $error("pingpong_frame_ram: SIZE must be a multiple of BYTE_W and DEPTH a power of two >= 2");
  end

  logic [0:0]    r_state;
  logic          r_wr_bank;
  logic          r_frame_avail;
  logic          r_swap;
  logic          r_overflow;
  logic          r_rv1;
  logic          w_swap_now;
  logic          w_ram_we;
  logic [SIZE-1:0] w_ram_q;

  // rd_done in the swap cycle is consumed by the hand-over, so frame_avail stays set.
  assign w_swap_now = (r_state == ST_WAIT_SWAP) && (!r_frame_avail || rd_done);
  assign w_ram_we   = write_en && (r_state == ST_FILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_FILL;
      r_wr_bank     <= 1'b0;
      r_frame_avail <= 1'b0;
      r_swap        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_swap <= w_swap_now;
      if (write_en && (r_state == ST_WAIT_SWAP)) r_overflow <= 1'b1;
      if (r_state == ST_FILL) begin
        if (rd_done) r_frame_avail <= 1'b0;
        if (wr_done) r_state       <= ST_WAIT_SWAP;
      end else if (w_swap_now) begin
        r_state       <= ST_FILL;
        r_wr_bank     <= ~r_wr_bank;
        r_frame_avail <= 1'b1;
      end
    end
  end

  sdp_ram_be #(
    .WIDTH  (SIZE),
    .ADDR_W (AW + 1),
    .BYTE_W (BYTE_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr ({r_wr_bank, waddr}),
    .wdata (write_data),
    .be    (write_be),
    .re    (read_en),
    .raddr ({~r_wr_bank, raddr}),
    .rdata (w_ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rv1 <= 1'b0;
    else        r_rv1 <= read_en;
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic            r_rv2;
    logic [SIZE-1:0] r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rv2   <= 1'b0;
        r_rdata <= '0;
      end else begin
        r_rv2 <= r_rv1;
        if (r_rv1) r_rdata <= w_ram_q;
      end
    end

    assign read_valid = r_rv2;
    assign read_data  = r_rdata;
  end else begin : g_no_out_reg
    logic r_seen;

    // The RAM output register is not reset; mask it until the first read lands.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_seen <= 1'b0;
      else        r_seen <= r_seen | r_rv1;
    end

    assign read_valid = r_rv1;
    assign read_data  = (r_seen || r_rv1) ? w_ram_q : '0;
  end

  assign wr_ready    = (r_state == ST_FILL);
  assign wr_overflow = r_overflow;
  assign frame_avail = r_frame_avail;
  assign swap        = r_swap;
  assign wr_bank     = r_wr_bank;

endmodule
`default_nettype wire

// File: tb/tb_pingpong_frame_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pingpong_frame_ram : directed + randomized bench against a frame-level model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_pingpong_frame_ram;

  localparam int unsigned SIZE   = 24;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LANES  = 3;
  localparam int unsigned AW     = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [AW-1:0]    waddr = '0;
  logic [AW-1:0]    raddr = '0;
  logic [SIZE-1:0]  write_data = '0;
  logic [LANES-1:0] write_be = '0;
  logic             write_en = 1'b0;
  logic             wr_done = 1'b0;
  logic             read_en = 1'b0;
  logic             rd_done = 1'b0;

  logic             wr_ready    [2];
  logic             wr_overflow [2];
  logic             read_valid  [2];
  logic             frame_avail [2];
  logic             swap        [2];
  logic             wr_bank     [2];
  logic [SIZE-1:0]  read_data   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pingpong_frame_ram #(.SIZE(SIZE), .DEPTH(DEPTH), .BYTE_W(BYTE_W), .OUT_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .waddr(waddr), .write_data(write_data), .write_be(write_be),
    .write_en(write_en), .wr_done(wr_done), .wr_ready(wr_ready[0]), .wr_overflow(wr_overflow[0]),
    .raddr(raddr), .read_en(read_en), .read_data(read_data[0]), .read_valid(read_valid[0]),
    .rd_done(rd_done), .frame_avail(frame_avail[0]), .swap(swap[0]), .wr_bank(wr_bank[0])
  );

  pingpong_frame_ram #(.SIZE(SIZE), .DEPTH(DEPTH), .BYTE_W(BYTE_W), .OUT_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .waddr(waddr), .write_data(write_data), .write_be(write_be),
    .write_en(write_en), .wr_done(wr_done), .wr_ready(wr_ready[1]), .wr_overflow(wr_overflow[1]),
    .raddr(raddr), .read_en(read_en), .read_data(read_data[1]), .read_valid(read_valid[1]),
    .rd_done(rd_done), .frame_avail(frame_avail[1]), .swap(swap[1]), .wr_bank(wr_bank[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: two frame buffers, who owns which, and the read pipe.
  logic [SIZE-1:0] mm [2][DEPTH];
  bit              m_bank, m_wait, m_avail, m_ovf, m_swap;
  bit              m_v1, m_v2, m_p;
  logic [SIZE-1:0] m_d1 = '0, m_d2 = '0, m_pd = '0;

  task automatic model_edge();
    logic [SIZE-1:0] rd;
    bit hand_over;
    rd = mm[!m_bank][raddr];
    m_v2 = m_p;
    if (m_p) m_d2 = m_pd;
    m_p = read_en;
    if (read_en) m_pd = rd;
    m_v1 = read_en;
    if (read_en) m_d1 = rd;
    if (write_en) begin
      if (m_wait) m_ovf = 1'b1;
      else for (int l = 0; l < LANES; l++)
        if (write_be[l]) mm[m_bank][waddr][l*BYTE_W +: BYTE_W] = write_data[l*BYTE_W +: BYTE_W];
    end
    hand_over = m_wait && (!m_avail || rd_done);
    m_swap = hand_over;
    if (hand_over) begin
      m_bank  = !m_bank;
      m_avail = 1'b1;
      m_wait  = 1'b0;
    end else if (!m_wait) begin
      if (rd_done) m_avail = 1'b0;
      if (wr_done) m_wait  = 1'b1;
    end
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) mm[b][a] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_bank = 0; m_wait = 0; m_avail = 0; m_ovf = 0; m_swap = 0;
        m_v1 = 0; m_v2 = 0; m_p = 0; m_d1 = '0; m_d2 = '0; m_pd = '0;
      end else begin
        model_edge();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("dut%0d wr_ready", d),    32'(wr_ready[d]),    32'(!m_wait));
          chk($sformatf("dut%0d frame_avail", d), 32'(frame_avail[d]), 32'(m_avail));
          chk($sformatf("dut%0d swap", d),        32'(swap[d]),        32'(m_swap));
          chk($sformatf("dut%0d wr_bank", d),     32'(wr_bank[d]),     32'(m_bank));
          chk($sformatf("dut%0d wr_overflow", d), 32'(wr_overflow[d]), 32'(m_ovf));
          chk($sformatf("dut%0d read_valid", d),  32'(read_valid[d]),  32'(d == 0 ? m_v1 : m_v2));
          chk($sformatf("dut%0d read_data", d),   32'(read_data[d]),   32'(d == 0 ? m_d1 : m_d2));
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    write_en = 1'b0; wr_done = 1'b0; read_en = 1'b0; rd_done = 1'b0;
  endtask

  task automatic fill(input logic [SIZE-1:0] v);
    for (int a = 0; a < DEPTH; a++) begin
      write_en = 1'b1; waddr = AW'(a); write_data = v; write_be = '1;
      cyc();
    end
  endtask

  task automatic wait_swap(input int limit);
    int n = 0;
    while (!swap[0] && n < limit) begin
      cyc();
      n++;
    end
    chk("swap within bound", 32'(swap[0]), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Zero both banks so every later read has a known value.
    fill('0); wr_done = 1'b1; cyc(); wait_swap(5);
    fill('0); wr_done = 1'b1; cyc(); rd_done = 1'b1; cyc(); wait_swap(5);

    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("reset wr_ready", 32'(wr_ready[0]), 32'd1);
    chk("reset frame_avail", 32'(frame_avail[0]), 32'd0);
    chk("reset wr_bank", 32'(wr_bank[0]), 32'd0);
    chk("reset swap", 32'(swap[0]), 32'd0);
    chk("reset read_valid", 32'(read_valid[1]), 32'd0);
    chk("reset read_data", 32'(read_data[1]), 32'd0);
    rst_n = 1'b1;

    // Byte-enable merge then hand-over.
    write_en = 1'b1; waddr = 4'd5; write_data = 24'hAABBCC; write_be = 3'b111; cyc();
    write_en = 1'b1; waddr = 4'd5; write_data = 24'h112233; write_be = 3'b010; cyc();
    wr_done = 1'b1; cyc();
    chk("t1 wr_ready after wr_done", 32'(wr_ready[0]), 32'd0);
    cyc();
    chk("t1 swap", 32'(swap[0]), 32'd1);
    chk("t1 wr_bank", 32'(wr_bank[0]), 32'd1);
    chk("t1 frame_avail", 32'(frame_avail[0]), 32'd1);
    chk("t1 wr_ready", 32'(wr_ready[0]), 32'd1);
    raddr = 4'd5; read_en = 1'b1; cyc();
    chk("t1 d0 read_valid", 32'(read_valid[0]), 32'd1);
    chk("t1 d0 read_data", 32'(read_data[0]), 32'hAA22CC);
    chk("t1 d1 read_valid early", 32'(read_valid[1]), 32'd0);
    cyc();
    chk("t1 d1 read_valid", 32'(read_valid[1]), 32'd1);
    chk("t1 d1 read_data", 32'(read_data[1]), 32'hAA22CC);
    chk("t1 d0 read_data hold", 32'(read_data[0]), 32'hAA22CC);

    // Blocked swap with an overflowing write in the middle.
    write_en = 1'b1; waddr = 4'd0; write_data = 24'h0000AB; write_be = 3'b111; cyc();
    wr_done = 1'b1; cyc();
    for (int i = 0; i < 10; i++) begin
      write_en = (i == 3); waddr = 4'd0; write_data = 24'h555555; write_be = 3'b111;
      cyc();
      chk("t2 wr_ready held", 32'(wr_ready[0]), 32'd0);
      chk("t2 swap held", 32'(swap[0]), 32'd0);
    end
    chk("t2 overflow", 32'(wr_overflow[0]), 32'd1);
    rd_done = 1'b1; cyc();
    chk("t2 swap", 32'(swap[0]), 32'd1);
    chk("t2 wr_bank", 32'(wr_bank[0]), 32'd0);
    chk("t2 frame_avail", 32'(frame_avail[0]), 32'd1);
    raddr = 4'd0; read_en = 1'b1; cyc();
    chk("t2 old bank word", 32'(read_data[0]), 32'h0000AB);
    chk("t2 overflow sticky", 32'(wr_overflow[1]), 32'd1);

    // Stray handshakes.
    wr_done = 1'b1; cyc();
    chk("t3 waiting", 32'(wr_ready[0]), 32'd0);
    wr_done = 1'b1; cyc();
    chk("t3 repeat wr_done swap", 32'(swap[0]), 32'd0);
    chk("t3 repeat wr_done bank", 32'(wr_bank[0]), 32'd0);
    rd_done = 1'b1; cyc();
    chk("t3 swap", 32'(swap[0]), 32'd1);
    rd_done = 1'b1; cyc();
    chk("t3 release", 32'(frame_avail[0]), 32'd0);
    rd_done = 1'b1; cyc();
    chk("t3 stray rd_done avail", 32'(frame_avail[0]), 32'd0);
    chk("t3 stray rd_done swap", 32'(swap[0]), 32'd0);
    chk("t3 stray rd_done bank", 32'(wr_bank[0]), 32'd1);

    // Tear-free: reader scans the old frame while the writer refills.
    fill('0); wr_done = 1'b1; cyc(); wait_swap(5);
    for (int i = 0; i < DEPTH; i++) begin
      write_en = 1'b1; waddr = AW'(i); write_data = 24'h000001; write_be = 3'b111;
      read_en = 1'b1; raddr = AW'(i);
      cyc();
      chk("t4 scan valid", 32'(read_valid[0]), 32'd1);
      chk("t4 scan old frame", 32'(read_data[0]), 32'h000000);
    end
    wr_done = 1'b1; cyc();
    rd_done = 1'b1; cyc();
    chk("t4 swap", 32'(swap[0]), 32'd1);
    raddr = 4'd3; read_en = 1'b1; cyc();
    chk("t4 new frame", 32'(read_data[0]), 32'h000001);

    // Asynchronous reset in WAIT_SWAP with a read in flight.
    wr_done = 1'b1; read_en = 1'b1; raddr = 4'd1; cyc();
    chk("t5 pre wr_ready", 32'(wr_ready[0]), 32'd0);
    chk("t5 pre read_valid", 32'(read_valid[0]), 32'd1);
    chk("t5 pre wr_bank", 32'(wr_bank[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 wr_ready", 32'(wr_ready[0]), 32'd1);
    chk("t5 frame_avail", 32'(frame_avail[0]), 32'd0);
    chk("t5 read_valid", 32'(read_valid[0]), 32'd0);
    chk("t5 wr_bank", 32'(wr_bank[0]), 32'd0);
    chk("t5 d1 wr_bank", 32'(wr_bank[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    for (int c = 0; c < 600; c++) begin
      write_en   = 1'($urandom_range(0, 1));
      waddr      = AW'($urandom);
      write_data = SIZE'($urandom);
      write_be   = LANES'($urandom);
      wr_done    = ($urandom_range(0, 9) == 0);
      read_en    = 1'($urandom_range(0, 1));
      raddr      = AW'($urandom);
      rd_done    = ($urandom_range(0, 7) == 0);
      cyc();
    end
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
